// File: rtl/motor_mix_scheduler_pkg.sv
// Shared definitions for the motor mix scheduler slice.
//   - FSM state encoding and its width
//   - per-motor operand sign table {yaw, roll, pitch}, 1 = negate
//   - default widths and ESC window limits
package motor_mix_scheduler_pkg;

  localparam int BIT_WIDTH_DEFAULT            = 16;
  localparam int MOTOR_RATE_BIT_WIDTH_DEFAULT = 8;
  localparam int MIX_STATE_BIT_WIDTH          = 2;

  localparam logic [MOTOR_RATE_BIT_WIDTH_DEFAULT-1:0] ESC_MIN_DEFAULT = 8'h10;
  localparam logic [MOTOR_RATE_BIT_WIDTH_DEFAULT-1:0] ESC_MAX_DEFAULT = 8'h7C;

  localparam logic [BIT_WIDTH_DEFAULT-1:0] ZERO = '0;

  typedef enum logic [MIX_STATE_BIT_WIDTH-1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } mix_state_t;

  // Indexed by motor number minus one; bit2 = yaw, bit1 = roll, bit0 = pitch.
  localparam logic [3:0][2:0] SIGN_TABLE = {3'b110,   // motor 4
                                            3'b000,   // motor 3
                                            3'b011,   // motor 2
                                            3'b101};  // motor 1

endpackage

// File: rtl/motor_mix_scheduler_if.sv
// Bus bundle between the mix scheduler, its PID/ESC neighbours and the
// shared external rate calculator.
//   master : drives start, the four PID rates and calc_result
//   slave  : the scheduler; drives calc_* operands, motor rates and status
interface motor_mix_scheduler_if #(
  parameter int BIT_WIDTH            = 16,
  parameter int MOTOR_RATE_BIT_WIDTH = 8
);
  logic                            start;
  logic [BIT_WIDTH-1:0]            yaw_rate;
  logic [BIT_WIDTH-1:0]            roll_rate;
  logic [BIT_WIDTH-1:0]            pitch_rate;
  logic [BIT_WIDTH-1:0]            throttle_rate;
  logic [BIT_WIDTH-1:0]            calc_yaw;
  logic [BIT_WIDTH-1:0]            calc_roll;
  logic [BIT_WIDTH-1:0]            calc_pitch;
  logic [BIT_WIDTH-1:0]            calc_throttle;
  logic [BIT_WIDTH-1:0]            calc_result;
  logic [MOTOR_RATE_BIT_WIDTH-1:0] motor_1_rate;
  logic [MOTOR_RATE_BIT_WIDTH-1:0] motor_2_rate;
  logic [MOTOR_RATE_BIT_WIDTH-1:0] motor_3_rate;
  logic [MOTOR_RATE_BIT_WIDTH-1:0] motor_4_rate;
  logic                            busy;
  logic                            done;
  logic [3:0]                      range_fault;
  logic                            start_dropped;

  modport master (
    output start, yaw_rate, roll_rate, pitch_rate, throttle_rate, calc_result,
    input  calc_yaw, calc_roll, calc_pitch, calc_throttle,
    input  motor_1_rate, motor_2_rate, motor_3_rate, motor_4_rate,
    input  busy, done, range_fault, start_dropped
  );

  modport slave (
    input  start, yaw_rate, roll_rate, pitch_rate, throttle_rate, calc_result,
    output calc_yaw, calc_roll, calc_pitch, calc_throttle,
    output motor_1_rate, motor_2_rate, motor_3_rate, motor_4_rate,
    output busy, done, range_fault, start_dropped
  );
endinterface

// File: rtl/motor_rate_mapper.sv
// Combinational round / shift / ESC range check of one calculator result.
//   result : signed calculator output (BIT_WIDTH)
//   mapped : result rounded half-up to MOTOR_RATE_BIT_WIDTH bits
//   fault  : result negative or mapped value outside [ESC_MIN, ESC_MAX]
module motor_rate_mapper #(
  parameter int BIT_WIDTH            = 16,
  parameter int MOTOR_RATE_BIT_WIDTH = 8,
  parameter logic [MOTOR_RATE_BIT_WIDTH-1:0] ESC_MIN = 8'h10,
  parameter logic [MOTOR_RATE_BIT_WIDTH-1:0] ESC_MAX = 8'h7C
) (
  input  logic [BIT_WIDTH-1:0]            result,
  output logic [MOTOR_RATE_BIT_WIDTH-1:0] mapped,
  output logic                            fault
);
  localparam int SHIFT = BIT_WIDTH - MOTOR_RATE_BIT_WIDTH;
  localparam int ROUND = 1 << (SHIFT - 1);

  // One extra bit so the rounding add can never wrap.
  logic [BIT_WIDTH:0] sum;
  logic [BIT_WIDTH:0] wide;

  always_comb begin
    sum    = {1'b0, result} + (BIT_WIDTH + 1)'(ROUND);
    wide   = sum >> SHIFT;
    mapped = wide[MOTOR_RATE_BIT_WIDTH-1:0];
    // The full-width compare also catches the 2^MOTOR_RATE_BIT_WIDTH carry case.
    fault  = result[BIT_WIDTH-1]
           | (wide < (BIT_WIDTH + 1)'(ESC_MIN))
           | (wide > (BIT_WIDTH + 1)'(ESC_MAX));
  end
endmodule

// File: rtl/motor_mix_scheduler.sv
// Time-shares one external motor_rate_calculator across four motors.
// Latches the PID rates on start, issues sign-adjusted operands per motor,
// maps and range-checks each result, then publishes all four rates with done.
//   sys_clk, rst_n : clock, asynchronous active-low reset
//   bus (slave)    : start/rates in, calc_* out, calc_result in,
//                    motor_N_rate, busy, done, range_fault, start_dropped out
//
// state   | meaning
// IDLE    | waiting for start
// ISSUE   | registering operands for motor idx+1
// CAPTURE | sampling calc_result for motor idx+1
// DONE    | one-cycle done pulse; may accept a new start
module motor_mix_scheduler
  import motor_mix_scheduler_pkg::*;
#(
  parameter int BIT_WIDTH            = BIT_WIDTH_DEFAULT,
  parameter int MOTOR_RATE_BIT_WIDTH = MOTOR_RATE_BIT_WIDTH_DEFAULT,
  parameter logic [MOTOR_RATE_BIT_WIDTH-1:0] ESC_MIN = ESC_MIN_DEFAULT,
  parameter logic [MOTOR_RATE_BIT_WIDTH-1:0] ESC_MAX = ESC_MAX_DEFAULT
) (
  input  logic                 sys_clk,
  input  logic                 rst_n,
  motor_mix_scheduler_if.slave bus
);
  localparam logic [BIT_WIDTH-1:0] MOST_NEG = {1'b1, {(BIT_WIDTH-1){1'b0}}};
  localparam logic [BIT_WIDTH-1:0] MOST_POS = {1'b0, {(BIT_WIDTH-1){1'b1}}};

  mix_state_t state;
  logic [1:0] idx;

  logic [BIT_WIDTH-1:0] yaw_q, roll_q, pitch_q, throttle_q;
  logic [BIT_WIDTH-1:0] calc_yaw_q, calc_roll_q, calc_pitch_q, calc_throttle_q;

  logic [MOTOR_RATE_BIT_WIDTH-1:0] shadow    [4];
  logic [MOTOR_RATE_BIT_WIDTH-1:0] last_good [4];
  logic [MOTOR_RATE_BIT_WIDTH-1:0] motor_q   [4];
  logic [3:0] fault_shadow;
  logic [3:0] range_fault_q;
  logic       busy_q, done_q, start_dropped_q;

  logic [MOTOR_RATE_BIT_WIDTH-1:0] map_value;
  logic                            map_fault;

  // Negating the most-negative value would overflow; clamp it instead.
  function automatic logic [BIT_WIDTH-1:0] cond_neg(input logic [BIT_WIDTH-1:0] v,
                                                    input logic negate);
    if (!negate)        return v;
    if (v == MOST_NEG)  return MOST_POS;
    return -v;
  endfunction

  motor_rate_mapper #(
    .BIT_WIDTH           (BIT_WIDTH),
    .MOTOR_RATE_BIT_WIDTH(MOTOR_RATE_BIT_WIDTH),
    .ESC_MIN             (ESC_MIN),
    .ESC_MAX             (ESC_MAX)
  ) u_mapper (
    .result(bus.calc_result),
    .mapped(map_value),
    .fault (map_fault)
  );

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      idx             <= 2'd0;
      yaw_q           <= ZERO;
      roll_q          <= ZERO;
      pitch_q         <= ZERO;
      throttle_q      <= ZERO;
      calc_yaw_q      <= ZERO;
      calc_roll_q     <= ZERO;
      calc_pitch_q    <= ZERO;
      calc_throttle_q <= ZERO;
      for (int m = 0; m < 4; m++) begin
        shadow[m]    <= '0;
        last_good[m] <= '0;
        motor_q[m]   <= '0;
      end
      fault_shadow    <= 4'b0000;
      range_fault_q   <= 4'b0000;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      start_dropped_q <= 1'b0;
    end else begin
      done_q          <= 1'b0;
      start_dropped_q <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            yaw_q      <= bus.yaw_rate;
            roll_q     <= bus.roll_rate;
            pitch_q    <= bus.pitch_rate;
            throttle_q <= bus.throttle_rate;
            idx        <= 2'd0;
            busy_q     <= 1'b1;
            state      <= S_ISSUE;
          end else begin
            state <= S_IDLE;
          end
        end
        S_ISSUE: begin
          start_dropped_q <= bus.start;
          calc_yaw_q      <= cond_neg(yaw_q,   SIGN_TABLE[idx][2]);
          calc_roll_q     <= cond_neg(roll_q,  SIGN_TABLE[idx][1]);
          calc_pitch_q    <= cond_neg(pitch_q, SIGN_TABLE[idx][0]);
          calc_throttle_q <= throttle_q;
          state           <= S_CAPTURE;
        end
        S_CAPTURE: begin
          start_dropped_q <= bus.start;
          if (map_fault) begin
            shadow[idx] <= last_good[idx];
          end else begin
            shadow[idx]    <= map_value;
            last_good[idx] <= map_value;
          end
          fault_shadow[idx] <= map_fault;
          if (idx == 2'd3) begin
            // Motor 4's shadow is being written this same edge, so use the fresh value.
            motor_q[0]    <= shadow[0];
            motor_q[1]    <= shadow[1];
            motor_q[2]    <= shadow[2];
            motor_q[3]    <= map_fault ? last_good[3] : map_value;
            range_fault_q <= {map_fault, fault_shadow[2:0]};
            busy_q        <= 1'b0;
            done_q        <= 1'b1;
            state         <= S_DONE;
          end else begin
            idx   <= idx + 2'd1;
            state <= S_ISSUE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.calc_yaw      = calc_yaw_q;
  assign bus.calc_roll     = calc_roll_q;
  assign bus.calc_pitch    = calc_pitch_q;
  assign bus.calc_throttle = calc_throttle_q;
  assign bus.motor_1_rate  = motor_q[0];
  assign bus.motor_2_rate  = motor_q[1];
  assign bus.motor_3_rate  = motor_q[2];
  assign bus.motor_4_rate  = motor_q[3];
  assign bus.range_fault   = range_fault_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.start_dropped = start_dropped_q;
endmodule

// File: tb/tb_motor_mix_scheduler.sv
// Self-checking bench for motor_mix_scheduler: directed scenarios followed by
// randomized mix requests, checked against an arithmetic reference model.
module tb_motor_mix_scheduler;
  logic sys_clk = 1'b0;
  logic rst_n   = 1'b0;
  int   total   = 0;
  int   bad     = 0;

  motor_mix_scheduler_if bus ();

  motor_mix_scheduler dut (
    .sys_clk(sys_clk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  always #5 sys_clk = ~sys_clk;

  // Shared external calculator: throttle + yaw/2 + roll/2 + pitch/2 (arithmetic shifts).
  always_comb
    bus.calc_result = $signed(bus.calc_throttle) + ($signed(bus.calc_yaw) >>> 1)
                    + ($signed(bus.calc_roll) >>> 1) + ($signed(bus.calc_pitch) >>> 1);

  // Reference model: +1 passes, -1 negates (motor 1..4).
  int sgn_y [4] = '{-1,  1, 1, -1};
  int sgn_r [4] = '{ 1, -1, 1, -1};
  int sgn_p [4] = '{-1, -1, 1,  1};
  int lg    [4] = '{0, 0, 0, 0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sx16(input logic [15:0] v);
    int t;
    t = $signed(v);
    return t;
  endfunction

  function automatic logic [15:0] operand(input logic [15:0] v, input int s);
    int x;
    x = sx16(v) * s;
    if (x > 32767) x = 32767;
    return 16'(x);
  endfunction

  function automatic logic [7:0] motor_out(input int k);
    case (k)
      0:       return bus.motor_1_rate;
      1:       return bus.motor_2_rate;
      2:       return bus.motor_3_rate;
      default: return bus.motor_4_rate;
    endcase
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge sys_clk);
      bus.start = 1'b0;
      @(posedge sys_clk);
      #1;
      check("idle_done", 32'(bus.done), 32'd0);
      check("idle_busy", 32'(bus.busy), 32'd0);
    end
  endtask

  // One full request; drop_at = edge (1..8) at which a second start is raised, 0 = none.
  task automatic run_mix(input logic [15:0] thr, input logic [15:0] y, input logic [15:0] r,
                         input logic [15:0] p, input int drop_at);
    logic [15:0] oy [4];
    logic [15:0] orr[4];
    logic [15:0] op [4];
    logic [7:0]  exp_rate[4];
    logic [3:0]  exp_fault;
    int res, mapped, k;
    bit flt;
    for (int m = 0; m < 4; m++) begin
      oy[m]  = operand(y, sgn_y[m]);
      orr[m] = operand(r, sgn_r[m]);
      op[m]  = operand(p, sgn_p[m]);
      res = sx16(thr) + (sx16(oy[m]) >>> 1) + (sx16(orr[m]) >>> 1) + (sx16(op[m]) >>> 1);
      res = res & 32'hFFFF;
      if (res >= 32768) res = res - 65536;
      mapped = (res + 128) / 256;
      flt = (res < 0) || (mapped < 16) || (mapped > 124);
      if (!flt) lg[m] = mapped;
      exp_rate[m]  = 8'(lg[m]);
      exp_fault[m] = flt;
    end
    @(negedge sys_clk);
    bus.throttle_rate = thr;
    bus.yaw_rate      = y;
    bus.roll_rate     = r;
    bus.pitch_rate    = p;
    bus.start         = 1'b1;
    @(posedge sys_clk);
    #1;
    check("accept_busy", 32'(bus.busy), 32'd1);
    check("accept_done", 32'(bus.done), 32'd0);
    for (int e = 1; e <= 8; e++) begin
      @(negedge sys_clk);
      bus.start = (e == drop_at);
      bus.throttle_rate = 16'($urandom);
      bus.yaw_rate      = 16'($urandom);
      bus.roll_rate     = 16'($urandom);
      bus.pitch_rate    = 16'($urandom);
      @(posedge sys_clk);
      #1;
      check($sformatf("start_dropped_e%0d", e), 32'(bus.start_dropped), 32'(e == drop_at));
      if (e % 2 == 1) begin
        k = (e - 1) / 2;
        check($sformatf("calc_yaw_m%0d", k + 1),      32'(bus.calc_yaw),      32'(oy[k]));
        check($sformatf("calc_roll_m%0d", k + 1),     32'(bus.calc_roll),     32'(orr[k]));
        check($sformatf("calc_pitch_m%0d", k + 1),    32'(bus.calc_pitch),    32'(op[k]));
        check($sformatf("calc_throttle_m%0d", k + 1), 32'(bus.calc_throttle), 32'(thr));
      end
      if (e < 8) begin
        check($sformatf("busy_e%0d", e), 32'(bus.busy), 32'd1);
        check($sformatf("done_e%0d", e), 32'(bus.done), 32'd0);
      end else begin
        check("busy_end", 32'(bus.busy), 32'd0);
        check("done_end", 32'(bus.done), 32'd1);
        check("range_fault", 32'(bus.range_fault), 32'(exp_fault));
        for (int m = 0; m < 4; m++)
          check($sformatf("m%0d_rate", m + 1), 32'(motor_out(m)), 32'(exp_rate[m]));
      end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.throttle_rate = '0;
    bus.yaw_rate = '0;
    bus.roll_rate = '0;
    bus.pitch_rate = '0;
    repeat (2) @(posedge sys_clk);
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_fault", 32'(bus.range_fault), 32'd0);
    check("rst_m1", 32'(bus.motor_1_rate), 32'd0);
    check("rst_m4", 32'(bus.motor_4_rate), 32'd0);
    check("rst_calc_yaw", 32'(bus.calc_yaw), 32'd0);
    check("rst_drop", 32'(bus.start_dropped), 32'd0);
    @(negedge sys_clk);
    rst_n = 1'b1;
    idle(1);

    // Hover, roll split, rounding boundary
    run_mix(16'h6000, 16'h0000, 16'h0000, 16'h0000, 0);
    check("hover_m2_literal", 32'(bus.motor_2_rate), 32'h60);
    run_mix(16'h6000, 16'h0000, 16'h1000, 16'h0000, 0);
    check("roll_m1_literal", 32'(bus.motor_1_rate), 32'h68);
    check("roll_m2_literal", 32'(bus.motor_2_rate), 32'h58);
    idle(2);
    run_mix(16'h607F, 16'h0000, 16'h0000, 16'h0000, 0);
    run_mix(16'h6080, 16'h0000, 16'h0000, 16'h0000, 0);
    check("round_up_literal", 32'(bus.motor_3_rate), 32'h61);

    // Out-of-window and negative results hold the last good values
    run_mix(16'h6000, 16'h0000, 16'h0000, 16'h0000, 0);
    run_mix(16'h0400, 16'h0000, 16'h0000, 16'h0000, 0);
    check("low_hold_literal", 32'(bus.range_fault), 32'hF);
    run_mix(16'h7E00, 16'h0000, 16'h0000, 16'h0000, 0);
    run_mix(16'hF000, 16'h0000, 16'h0000, 16'h0000, 0);
    check("neg_hold_literal", 32'(bus.motor_4_rate), 32'h60);

    // Overrun start and most-negative yaw saturation
    run_mix(16'h5000, 16'h8000, 16'h0000, 16'h0000, 3);
    idle(1);

    // Reset in the middle of a sequence
    @(negedge sys_clk);
    bus.throttle_rate = 16'h4000;
    bus.start = 1'b1;
    @(posedge sys_clk);
    for (int e = 1; e <= 4; e++) begin
      @(negedge sys_clk);
      bus.start = 1'b0;
      @(posedge sys_clk);
    end
    @(negedge sys_clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_m1", 32'(bus.motor_1_rate), 32'd0);
    check("midrst_m3", 32'(bus.motor_3_rate), 32'd0);
    check("midrst_calc_thr", 32'(bus.calc_throttle), 32'd0);
    repeat (2) begin
      @(posedge sys_clk);
      #1;
      check("midrst_done", 32'(bus.done), 32'd0);
    end
    @(negedge sys_clk);
    rst_n = 1'b1;
    for (int m = 0; m < 4; m++) lg[m] = 0;
    run_mix(16'h4000, 16'h0400, 16'hFC00, 16'h0200, 0);

    // Randomized requests, mixing back-to-back, gaps and overruns
    for (int i = 0; i < 24; i++) begin
      logic [15:0] t, yy, rr, pp;
      int d;
      t  = 16'($urandom_range(0, 16'h7FFF));
      yy = 16'($urandom_range(0, 16'h3FFF)) - 16'h2000;
      rr = 16'($urandom_range(0, 16'h3FFF)) - 16'h2000;
      pp = 16'($urandom_range(0, 16'h3FFF)) - 16'h2000;
      if ($urandom_range(0, 5) == 0) yy = 16'h8000;
      if ($urandom_range(0, 7) == 0) t  = 16'($urandom);
      d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 0;
      run_mix(t, yy, rr, pp, d);
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/motor_mix_scheduler.md
Name: motor_mix_scheduler

Overview:
- Time-shares one `motor_rate_calculator` instance across all four motors.
- Per request:
  - latches the PID rates;
  - drives per-motor sign-adjusted operands into the shared calculator;
  - captures, rounds and maps each 16-bit result to 8 bits;
  - range-checks each result against ESC limits;
  - publishes all four motor rates together with a done pulse.
- Sits between the PID rate outputs and the ESC/PWM drivers; replaces four parallel calculators.

Parameters:
- BIT_WIDTH, 16: width of rate inputs, calculator operands and calculator result.
- MOTOR_RATE_BIT_WIDTH, 8: width of motor outputs.
- ESC_MIN, 8'h10: lowest legal mapped motor rate (inclusive).
- ESC_MAX, 8'h7C: highest legal mapped motor rate (inclusive).

Ports:
- sys_clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request a mix cycle; single-cycle pulse or level
- yaw_rate  in  BIT_WIDTH  signed two's complement
- roll_rate  in  BIT_WIDTH  signed two's complement
- pitch_rate  in  BIT_WIDTH  signed two's complement
- throttle_rate  in  BIT_WIDTH  signed two's complement
- calc_yaw  out  BIT_WIDTH  registered operand to shared calculator
- calc_roll  out  BIT_WIDTH  registered operand to shared calculator
- calc_pitch  out  BIT_WIDTH  registered operand to shared calculator
- calc_throttle  out  BIT_WIDTH  registered operand to shared calculator
- calc_result  in  BIT_WIDTH  combinational calculator output, signed
- motor_1_rate  out  MOTOR_RATE_BIT_WIDTH  mapped rate, motor 1
- motor_2_rate  out  MOTOR_RATE_BIT_WIDTH  mapped rate, motor 2
- motor_3_rate  out  MOTOR_RATE_BIT_WIDTH  mapped rate, motor 3
- motor_4_rate  out  MOTOR_RATE_BIT_WIDTH  mapped rate, motor 4
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse; motor outputs updated this cycle
- range_fault  out  4  per-motor flag (bit0 = motor 1); valid with done, held until next done
- start_dropped  out  1  one-cycle pulse when start arrives while busy

Behaviour:
- Reset (async, rst_n=0):
  - state = IDLE; motor_N_rate, internal last-good values and shadows = 0;
  - calc_* = 0; busy = done = start_dropped = 0; range_fault = 0.
  - Reset mid-sequence aborts immediately; no partial output update.
- FSM states: IDLE, ISSUE, CAPTURE, DONE. Motor index idx (0..3) is a 2-bit counter.
- IDLE or DONE, start=1:
  - latch all four rate inputs; idx = 0; busy = 1; go to ISSUE.
  - Back-to-back starts are allowed from DONE.
- ISSUE: register calc_* for motor idx+1 using the sign table below; go to CAPTURE.
- CAPTURE: sample calc_result, map it, range-check it, and write the shadow value and fault bit for idx.
  - idx<3: idx++ and go to ISSUE.
  - idx==3: copy all shadows to motor_N_rate together; update range_fault; done = 1; busy = 0; go to DONE.
- DONE, no start: go to IDLE. done is high exactly one cycle.
- Latency: start sampled at edge 0 → outputs and done registered at edge 8. Minimum start-to-start period is 9 cycles.
- Sign table (+ passes the operand, − negates it; throttle always passed):
  - M1: yaw −, roll +, pitch −
  - M2: yaw +, roll −, pitch −
  - M3: yaw +, roll +, pitch +
  - M4: yaw −, roll −, pitch +
- Negation: two's complement. The most-negative value (16'h8000) saturates to 16'h7FFF.
- Mapping:
  - If calc_result is negative (MSB=1) → fault.
  - Otherwise mapped = (result + 2^(BIT_WIDTH−MOTOR_RATE_BIT_WIDTH−1)) >> (BIT_WIDTH−MOTOR_RATE_BIT_WIDTH), i.e. round half up.
  - Computed in BIT_WIDTH+1 bits, so no overflow.
- Range check:
  - Fault if mapped < ESC_MIN, mapped > ESC_MAX, or result negative.
  - On fault: shadow = that motor's last-good value; fault bit = 1.
  - Otherwise: shadow = mapped; last-good = mapped; fault bit = 0.
- Input latching: inputs changing during busy have no effect on the current cycle.
- start while busy (ISSUE/CAPTURE): ignored; start_dropped pulses one cycle (registered).

Decomposition:
- Shared package/defines:
  - FSM state encodings and MIX_STATE_BIT_WIDTH;
  - sign table as per-motor 3-bit constants {yaw, roll, pitch}, 1 = negate;
  - ZERO;
  - default ESC_MIN/ESC_MAX.
- One natural sub-module: `motor_rate_mapper`, combinational round/shift/range check producing mapped value and fault. It is instantiated once inside the scheduler.
- The calculator stays external and shared.

Test Plan:
- Bench calculator model: result = throttle + (yaw>>>1) + (roll>>>1) + (pitch>>>1).
- Hover: throttle 16'h6000, others 0; start pulse → done at edge 8; all motors 8'h60; range_fault 4'b0000; busy high edges 0–8.
- Roll: throttle 16'h6000, roll 16'h1000 → M1 = M3 = 8'h68; M2 = M4 = 8'h58; calc_roll driven ±16'h1000 in the correct order.
- Rounding: throttle 16'h607F → 8'h60; throttle 16'h6080 → 8'h61.
- Range/hold:
  - After a 16'h6000 run, throttle 16'h0400 → all outputs stay 8'h60, range_fault 4'b1111.
  - Throttle 16'h7E00 → hold, faults 4'b1111.
  - Throttle 16'hF000 (negative) → hold, faults 4'b1111.
- Overrun/negation: start at edge 3 of a cycle → start_dropped pulse, sequence unaffected. yaw 16'h8000 → M1/M4 calc_yaw = 16'h7FFF.
- Reset mid-op: rst_n low at edge 5 → outputs 0, busy 0, no done. Next start → clean full sequence.
